// File: rtl/led_blinker_array_if.sv
// Configuration write port and LED status bundle for led_blinker_array.
// The control logic sits on the master side and the blinker on the slave side.
interface led_blinker_array_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              enable;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_interval;
    logic [CNT_W-1:0]  cfg_on_len;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] active;

    modport master (
        output enable,
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_interval,
        output cfg_on_len,
        input  led,
        input  wrap,
        input  active
    );

    modport slave (
        input  enable,
        input  cfg_we,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_interval,
        input  cfg_on_len,
        output led,
        output wrap,
        output active
    );
endinterface

// File: rtl/led_blinker_array.sv
// Multi-channel LED pattern generator: shared prescaled tick and LFSR, per-channel
// off / periodic / one-shot / pseudo-random-interval sequencing with registered outputs.
module led_blinker_array #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk_i,
    input  logic               rstbtn_i,
    led_blinker_array_if.slave bus_io
);
    localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ModeOff      = 2'b00,
        ModePeriodic = 2'b01,
        ModeOneShot  = 2'b10,
        ModeRandom   = 2'b11
    } mode_e;

    logic [PRE_W-1:0]  pre_q;
    logic              tick;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic [CNT_W-1:0]  rnd_ivl;
    mode_e             req_mode;
    mode_e             wr_mode;
    logic              wr_led;
    logic [NUM_CH-1:0] led_vec;
    logic [NUM_CH-1:0] wrap_vec;
    logic [NUM_CH-1:0] active_vec;

    assign tick = bus_io.enable && (pre_q == PRE_LAST);

    always_ff @(posedge clk_i or posedge rstbtn_i) begin
        if (rstbtn_i) begin
            pre_q <= '0;
        end else if (bus_io.enable) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

    // Galois LFSR free-runs every clock, independent of enable.
    assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign rnd_ivl = lfsr_q[CNT_W-1:0] | CNT_ONE;

    always_ff @(posedge clk_i or posedge rstbtn_i) begin
        if (rstbtn_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Decode of the written configuration, shared by all channels.
    always_comb begin
        req_mode = mode_e'(bus_io.cfg_mode);
        wr_mode  = req_mode;
        if (req_mode == ModeOneShot && bus_io.cfg_on_len == '0) begin
            wr_mode = ModeOff;
        end
        wr_led = (req_mode != ModeOff) && (bus_io.cfg_on_len != '0) &&
                 ((bus_io.cfg_interval != '0) || (req_mode == ModeOneShot));
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        mode_e            mode_q;
        logic [CNT_W-1:0] interval_q;
        logic [CNT_W-1:0] on_len_q;
        logic [CNT_W-1:0] cnt_q;
        logic             led_q;
        logic             wrap_q;
        logic             sel;
        logic             per_end;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] cnt_nx;

        assign sel = bus_io.cfg_we && (bus_io.cfg_ch == CH_W'(gi));

        always_comb begin
            cnt_inc = cnt_q + CNT_ONE;
            per_end = (cnt_q == interval_q - CNT_ONE);
            cnt_nx  = per_end ? '0 : cnt_inc;
        end

        // A write to this channel wins over a coincident tick.
        always_ff @(posedge clk_i or posedge rstbtn_i) begin
            if (rstbtn_i) begin
                mode_q     <= ModeOff;
                interval_q <= '0;
                on_len_q   <= '0;
                cnt_q      <= '0;
                led_q      <= 1'b0;
                wrap_q     <= 1'b0;
            end else if (sel) begin
                mode_q     <= wr_mode;
                interval_q <= bus_io.cfg_interval;
                on_len_q   <= bus_io.cfg_on_len;
                cnt_q      <= '0;
                led_q      <= wr_led;
                wrap_q     <= 1'b0;
            end else if (tick) begin
                unique case (mode_q)
                    ModeOff: begin
                        cnt_q  <= '0;
                        led_q  <= 1'b0;
                        wrap_q <= 1'b0;
                    end
                    ModePeriodic, ModeRandom: begin
                        if (interval_q == '0) begin
                            cnt_q  <= '0;
                            led_q  <= 1'b0;
                            wrap_q <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_nx;
                            wrap_q <= per_end;
                            led_q  <= (cnt_nx < on_len_q);
                            if (mode_q == ModeRandom && per_end) begin
                                interval_q <= rnd_ivl;
                            end
                        end
                    end
                    ModeOneShot: begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == on_len_q) begin
                            mode_q <= ModeOff;
                            wrap_q <= 1'b1;
                            led_q  <= 1'b0;
                        end else begin
                            wrap_q <= 1'b0;
                            led_q  <= (cnt_inc < on_len_q);
                        end
                    end
                endcase
            end else begin
                wrap_q <= 1'b0;
            end
        end

        assign led_vec[gi]    = led_q;
        assign wrap_vec[gi]   = wrap_q;
        assign active_vec[gi] = (mode_q != ModeOff);
    end

    assign bus_io.led    = led_vec;
    assign bus_io.wrap   = wrap_vec;
    assign bus_io.active = active_vec;
endmodule

// File: tb/tb_led_blinker_array.sv
// Bench for led_blinker_array: two instances (4ch/PRESCALE 1, 3ch/PRESCALE 4) compared
// every cycle against a ticks-since-write reference model.
module tb_led_blinker_array;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    led_blinker_array_if #(.NUM_CH(4), .CNT_W(5)) ifa ();
    led_blinker_array_if #(.NUM_CH(3), .CNT_W(8)) ifb ();

    led_blinker_array #(
        .NUM_CH(4), .CNT_W(5), .PRESCALE(1), .LFSR_SEED(16'hACE1)
    ) dut_a (
        .clk_i(clk), .rstbtn_i(rst), .bus_io(ifa)
    );

    led_blinker_array #(
        .NUM_CH(3), .CNT_W(8), .PRESCALE(4), .LFSR_SEED(16'hACE1)
    ) dut_b (
        .clk_i(clk), .rstbtn_i(rst), .bus_io(ifb)
    );

    typedef struct {
        int mode;
        int ivl;
        int on;
        int k;
        int pst;
        int cur;
        bit led;
        bit wrap;
    } ch_t;

    ch_t ma[4];
    ch_t mb[3];
    int  lfsr_m;
    int  en_b;
    int  wraps_m3;
    bit  tick_a;
    bit  tick_b;
    int  tests = 0;
    int  fails = 0;

    // k counts ticks since the last write; the level follows from the position in the period.
    function automatic ch_t step(input ch_t c, input bit wr, input int md, input int ivl,
                                 input int on, input bit tick, input int rnd);
        ch_t n = c;
        int  ph;
        n.wrap = 1'b0;
        if (wr) begin
            n.mode = (md == 2 && on == 0) ? 0 : md;
            n.ivl  = ivl;
            n.on   = on;
            n.k    = 0;
            n.pst  = 0;
            n.cur  = ivl;
            n.led  = (md != 0) && (on != 0) && (ivl != 0 || md == 2);
        end else if (tick) begin
            case (n.mode)
                0: n.led = 1'b0;
                1: begin
                    if (n.ivl == 0) n.led = 1'b0;
                    else begin
                        n.k++;
                        ph     = n.k % n.ivl;
                        n.wrap = (ph == 0);
                        n.led  = (ph < n.on);
                    end
                end
                3: begin
                    if (n.cur == 0) n.led = 1'b0;
                    else begin
                        n.k++;
                        ph = n.k - n.pst;
                        if (ph == n.cur) begin
                            n.wrap = 1'b1;
                            n.pst  = n.k;
                            n.cur  = rnd;
                            ph     = 0;
                        end
                        n.led = (ph < n.on);
                    end
                end
                default: begin
                    n.k++;
                    if (n.k == n.on) begin
                        n.mode = 0;
                        n.wrap = 1'b1;
                        n.led  = 1'b0;
                    end else begin
                        n.led = (n.k < n.on);
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic ch_t ch_zero();
        ch_t z;
        z.mode = 0; z.ivl = 0; z.on = 0; z.k = 0; z.pst = 0; z.cur = 0;
        z.led = 1'b0; z.wrap = 1'b0;
        return z;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ma[i] = ch_zero();
            for (int i = 0; i < 3; i++) mb[i] = ch_zero();
            lfsr_m = 16'hACE1;
            en_b   = 0;
        end else begin
            tick_a = ifa.enable;
            tick_b = ifb.enable && (en_b % 4 == 3);
            if (ifb.enable) en_b++;
            for (int i = 0; i < 4; i++) begin
                ma[i] = step(ma[i], ifa.cfg_we && int'(ifa.cfg_ch) == i, int'(ifa.cfg_mode),
                             int'(ifa.cfg_interval), int'(ifa.cfg_on_len), tick_a,
                             (lfsr_m & 31) | 1);
            end
            for (int i = 0; i < 3; i++) begin
                mb[i] = step(mb[i], ifb.cfg_we && int'(ifb.cfg_ch) == i, int'(ifb.cfg_mode),
                             int'(ifb.cfg_interval), int'(ifb.cfg_on_len), tick_b,
                             (lfsr_m & 255) | 1);
            end
            if (ma[3].wrap) wraps_m3++;
            lfsr_m = (lfsr_m >> 1) ^ (((lfsr_m & 1) != 0) ? 'hB400 : 0);
        end
    end

    task automatic chk_bit(input logic obs, input logic exp, input string tag, input int idx);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s[%0d] at %0t: got %b expected %b", tag, idx, $time, obs, exp);
        end
    endtask

    task automatic chk_int(input int obs, input int exp, input string tag);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk_bit(ifa.led[i], ma[i].led, "a_led", i);
            chk_bit(ifa.wrap[i], ma[i].wrap, "a_wrap", i);
            chk_bit(ifa.active[i], ma[i].mode != 0, "a_active", i);
        end
        for (int i = 0; i < 3; i++) begin
            chk_bit(ifb.led[i], mb[i].led, "b_led", i);
            chk_bit(ifb.wrap[i], mb[i].wrap, "b_wrap", i);
            chk_bit(ifb.active[i], mb[i].mode != 0, "b_active", i);
        end
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk_bit(ifa.led[i], 1'b0, {tag, "_a_led"}, i);
            chk_bit(ifa.wrap[i], 1'b0, {tag, "_a_wrap"}, i);
            chk_bit(ifa.active[i], 1'b0, {tag, "_a_active"}, i);
        end
        for (int i = 0; i < 3; i++) begin
            chk_bit(ifb.led[i], 1'b0, {tag, "_b_led"}, i);
            chk_bit(ifb.active[i], 1'b0, {tag, "_b_active"}, i);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr_a(input int ch, input int md, input int ivl, input int on);
        ifa.cfg_we       = 1'b1;
        ifa.cfg_ch       = 2'(ch);
        ifa.cfg_mode     = 2'(md);
        ifa.cfg_interval = 5'(ivl);
        ifa.cfg_on_len   = 5'(on);
        cyc();
        ifa.cfg_we = 1'b0;
    endtask

    task automatic wr_b(input int ch, input int md, input int ivl, input int on);
        ifb.cfg_we       = 1'b1;
        ifb.cfg_ch       = 2'(ch);
        ifb.cfg_mode     = 2'(md);
        ifb.cfg_interval = 8'(ivl);
        ifb.cfg_on_len   = 8'(on);
        cyc();
        ifb.cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        int dut_w;
        int m0;
        int guard;

        wraps_m3         = 0;
        ifa.enable       = 1'b0;
        ifa.cfg_we       = 1'b0;
        ifa.cfg_ch       = '0;
        ifa.cfg_mode     = '0;
        ifa.cfg_interval = '0;
        ifa.cfg_on_len   = '0;
        ifb.enable       = 1'b0;
        ifb.cfg_we       = 1'b0;
        ifb.cfg_ch       = '0;
        ifb.cfg_mode     = '0;
        ifb.cfg_interval = '0;
        ifb.cfg_on_len   = '0;
        rst = 1'b1;
        #3;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Periodic channels on the PRESCALE=1 instance, 12-cycle period on the other.
        ifa.enable = 1'b1;
        ifb.enable = 1'b1;
        wr_a(0, 1, 10, 1);
        wr_a(1, 1, 5, 2);
        wr_b(0, 1, 3, 1);
        run(20);
        ifb.enable = 1'b0;
        run(7);
        ifb.enable = 1'b1;
        run(30);

        // One-shot, then rewrite with on_len 0.
        wr_a(2, 2, 9, 3);
        run(8);
        wr_a(2, 2, 4, 0);
        run(4);

        // Async reset between clock edges while channels run.
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run(6);
        check_idle("post_rst");

        // Edge cases on the 3-channel instance.
        wr_b(0, 1, 0, 3);
        wr_b(1, 1, 4, 6);
        run(40);
        for (int j = 0; j < 4; j++) begin
            wr_b(2, 1, 5, 2);
            run(j + 1);
        end
        run(30);
        wr_b(3, 1, 4, 1);
        run(12);

        // Randomised writes and enable on both instances.
        for (int t = 0; t < 400; t++) begin
            ifa.cfg_we = ($urandom_range(0, 3) == 0);
            ifa.cfg_ch = 2'($urandom_range(0, 3));
            ifa.cfg_mode = 2'($urandom_range(0, 3));
            ifa.cfg_interval = 5'($urandom_range(0, 12));
            ifa.cfg_on_len = 5'($urandom_range(0, 12));
            ifb.cfg_we = ($urandom_range(0, 3) == 0);
            ifb.cfg_ch = 2'($urandom_range(0, 3));
            ifb.cfg_mode = 2'($urandom_range(0, 3));
            ifb.cfg_interval = 8'($urandom_range(0, 10));
            ifb.cfg_on_len = 8'($urandom_range(0, 10));
            ifb.enable = ($urandom_range(0, 7) != 0);
            cyc();
        end
        ifa.cfg_we = 1'b0;
        ifb.cfg_we = 1'b0;
        ifb.enable = 1'b1;
        ifa.enable = 1'b1;

        // Random-interval mode: first wrap after cfg_interval ticks, then LFSR periods.
        wr_a(3, 3, 7, 2);
        n = 0;
        do begin
            cyc();
            n++;
        end while (ifa.wrap[3] !== 1'b1 && n < 40);
        chk_int(n, 7, "rnd_first_wrap");

        m0    = wraps_m3;
        dut_w = 0;
        guard = 0;
        while (dut_w < 1000 && guard < 40000) begin
            cyc();
            guard++;
            if (ifa.wrap[3] === 1'b1) dut_w++;
        end
        chk_int(dut_w, 1000, "rnd_wrap_count");
        chk_int(wraps_m3 - m0, dut_w, "rnd_model_wraps");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
